// File: rtl/alu_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_chk_pkg
// Purpose  : Shared types and constants for the ALU result checker: checker
//            FSM state encoding, field widths and the bit positions of the
//            {op, A, B, Zexp} fields inside an expected vector.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package alu_chk_pkg;

  localparam int OP_W    = 2;
  localparam int D_W     = 3;
  localparam int VEC_W   = 11;
  // One FIFO entry = expected vector plus its "last" tag in bit 0.
  localparam int ENTRY_W = VEC_W + 1;

  // LSB positions of each field in exp_vec = {op, A, B, Zexp}.
  localparam int OP_LSB   = 3 * D_W;
  localparam int A_LSB    = 2 * D_W;
  localparam int B_LSB    = D_W;
  localparam int ZEXP_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  function automatic logic [D_W-1:0] zexp_of(input logic [VEC_W-1:0] vec);
    return vec[ZEXP_LSB +: D_W];
  endfunction

endpackage : alu_chk_pkg
`default_nettype wire

// File: rtl/alu_result_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_checker_if
// Purpose  : Bundle of the expected-vector handshake, ALU result input and
//            checker status outputs.
// Ports    : master - drives exp_valid/exp_vec/exp_last/res_valid/res_z and
//                     observes the status outputs
//            slave  - the checker side (exp_ready and all status outputs)
// Revision : 1.0 - initial release
// ============================================================================
interface alu_result_checker_if #(
  parameter int CNT_W = 16
);

  logic                           exp_valid;
  logic                           exp_ready;
  logic [alu_chk_pkg::VEC_W-1:0]  exp_vec;
  logic                           exp_last;
  logic                           res_valid;
  logic [alu_chk_pkg::D_W-1:0]    res_z;
  logic [CNT_W-1:0]               vec_count;
  logic [CNT_W-1:0]               err_count;
  logic                           mismatch;
  logic [alu_chk_pkg::VEC_W-1:0]  mis_info;
  logic [alu_chk_pkg::D_W-1:0]    mis_z;
  logic                           underflow;
  logic                           done;

  modport master (
    output exp_valid, exp_vec, exp_last, res_valid, res_z,
    input  exp_ready, vec_count, err_count, mismatch, mis_info, mis_z,
           underflow, done
  );

  modport slave (
    input  exp_valid, exp_vec, exp_last, res_valid, res_z,
    output exp_ready, vec_count, err_count, mismatch, mis_info, mis_z,
           underflow, done
  );

endinterface : alu_result_checker_if
`default_nettype wire

// File: rtl/chk_fifo.sv
`default_nettype none
// ============================================================================
// Module   : chk_fifo
// Purpose  : Show-ahead FIFO holding expected entries. Pointers carry one
//            extra wrap bit so full and empty are told apart when the
//            index bits are equal.
// Ports    : clk, rst (async, active-low), clr_i (sync clear)
//            push_i/din_i   - write (ignored when full)
//            pop_i          - read  (ignored when empty)
//            dout_o         - head entry, valid while !empty_o
//            full_o/empty_o - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module chk_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w_push;
  logic w_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule : chk_fifo
`default_nettype wire

// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_checker
// Purpose  : Queues expected ALU vectors, compares each incoming ALU result
//            against the oldest queued Zexp, and keeps saturating vector and
//            error counts plus details of the most recent mismatch.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous reset, active-low
//            clr  - synchronous clear of FIFO, counters and FSM
//            bus  - alu_result_checker_if.slave: expected-entry handshake,
//                   ALU result input and all status outputs
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  alu_result_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e       state_q;
  logic             ready_en_q;
  logic [CNT_W-1:0] vec_count_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] vec_count_d;
  logic [CNT_W-1:0] err_count_d;
  logic             mismatch_q;
  logic [VEC_W-1:0] mis_info_q;
  logic [D_W-1:0]   mis_z_q;
  logic             underflow_q;
  logic             done_q;

  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [ENTRY_W-1:0] w_head;
  logic [VEC_W-1:0]   w_head_vec;
  logic               w_head_last;
  logic               w_exp_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_res_underflow;
  logic               w_head_mis;

  // ready_en_q keeps exp_ready low throughout reset even though the
  // FIFO reads not-full then; it rises on the first edge after release.
  assign w_exp_ready     = ready_en_q && !w_fifo_full && (state_q != ST_DONE);
  assign w_push          = bus.exp_valid && w_exp_ready;
  assign w_pop           = bus.res_valid && !w_fifo_empty && (state_q != ST_DONE);
  assign w_res_underflow = bus.res_valid && w_fifo_empty && (state_q != ST_DONE);

  assign {w_head_vec, w_head_last} = w_head;
  assign w_head_mis = (bus.res_z != zexp_of(w_head_vec));

  assign vec_count_d = (vec_count_q == CNT_MAX) ? vec_count_q : vec_count_q + CNT_ONE;
  assign err_count_d = (err_count_q == CNT_MAX) ? err_count_q : err_count_q + CNT_ONE;

  chk_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   ({bus.exp_vec, bus.exp_last}),
    .dout_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ready_en_q  <= 1'b0;
      vec_count_q <= '0;
      err_count_q <= '0;
      mismatch_q  <= 1'b0;
      mis_info_q  <= '0;
      mis_z_q     <= '0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (clr) begin
        state_q     <= ST_IDLE;
        vec_count_q <= '0;
        err_count_q <= '0;
        mismatch_q  <= 1'b0;
        mis_info_q  <= '0;
        mis_z_q     <= '0;
        underflow_q <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        mismatch_q <= 1'b0;

        if (w_res_underflow) underflow_q <= 1'b1;

        // Popping the tagged entry ends the run even if a push lands in the
        // same cycle; otherwise the first accepted push starts it.
        if (w_pop && w_head_last) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end else if (state_q == ST_IDLE && w_push) begin
          state_q <= ST_RUN;
        end

        if (w_pop) begin
          vec_count_q <= vec_count_d;
          if (w_head_mis) begin
            err_count_q <= err_count_d;
            mismatch_q  <= 1'b1;
            mis_info_q  <= w_head_vec;
            mis_z_q     <= bus.res_z;
          end
        end
      end
    end
  end

  assign bus.exp_ready = w_exp_ready;
  assign bus.vec_count = vec_count_q;
  assign bus.err_count = err_count_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.mis_info  = mis_info_q;
  assign bus.mis_z     = mis_z_q;
  assign bus.underflow = underflow_q;
  assign bus.done      = done_q;

endmodule : alu_result_checker
`default_nettype wire
